hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and
// ret-target wait with timeout, plus a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned RET_TIMEOUT       = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_ret,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_write,
  input  logic [3:0]  ex_reg_rd,
  input  logic        ex_pc_src,
  input  logic        ex_pc_update_done,
  output logic        hazard,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [1:0]  hz_state,
  output logic        ret_timeout_err,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    RWAIT  = 2'd2,
    BAD    = 2'd3
  } st_t;

  localparam logic [1:0] LS_INIT  = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] RET_LAST = 8'(RET_TIMEOUT - 1);

  st_t        state, state_nx;
  logic [1:0] remaining, remaining_nx;
  logic [7:0] ret_cnt, ret_cnt_nx;
  logic       err_set;
  logic       hz_c, fi_c, fe_c;

  logic rs_hit, rt_hit, load_use;
  logic pc_go, lu_go, rt_go, timeout;

  assign rs_hit   = id_uses_rs & (id_rs == ex_reg_rd);
  assign rt_hit   = id_uses_rt & (id_rt == ex_reg_rd);
  assign load_use = id_valid & ex_mem_to_reg & ex_reg_write
                  & (ex_reg_rd != 4'd0) & (rs_hit | rt_hit);

  // Mutually exclusive RUN decisions encode the priority order.
  assign pc_go   = ex_pc_src;
  assign lu_go   = ~ex_pc_src & load_use;
  assign rt_go   = ~ex_pc_src & ~load_use & id_valid & id_is_ret;
  assign timeout = (ret_cnt == RET_LAST) & ~ex_pc_update_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      remaining       <= 2'd0;
      ret_cnt         <= 8'd0;
      ret_timeout_err <= 1'b0;
      stall_cycles    <= 16'd0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      ret_cnt   <= ret_cnt_nx;
      if (err_set)
        ret_timeout_err <= 1'b1;
      if (hazard && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    ret_cnt_nx   = ret_cnt;
    err_set      = 1'b0;
    case (state)
      RUN: begin
        unique case (1'b1)
          pc_go: state_nx = RUN;
          lu_go: begin
            if (LOAD_STALL_CYCLES > 1) begin
              state_nx     = LSTALL;
              remaining_nx = LS_INIT;
            end else begin
              state_nx = RUN;
            end
          end
          rt_go: begin
            state_nx   = RWAIT;
            ret_cnt_nx = 8'd0;
          end
          default: state_nx = RUN;
        endcase
      end
      LSTALL: begin
        remaining_nx = remaining - 2'd1;
        if (remaining <= 2'd1)
          state_nx = RUN;
      end
      RWAIT: begin
        if (ex_pc_update_done) begin
          state_nx = RUN;
        end else if (timeout) begin
          state_nx = RUN;
          err_set  = 1'b1;
        end else begin
          ret_cnt_nx = ret_cnt + 8'd1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    hz_c = 1'b0;
    fi_c = 1'b0;
    fe_c = 1'b0;
    case (state)
      RUN: begin
        unique case (1'b1)
          pc_go: begin
            fi_c = 1'b1;
            fe_c = 1'b1;
          end
          lu_go: begin
            hz_c = 1'b1;
            fe_c = 1'b1;
          end
          rt_go: hz_c = 1'b1;
          default: ;
        endcase
      end
      LSTALL: begin
        hz_c = 1'b1;
        fe_c = 1'b1;
      end
      RWAIT: begin
        if (ex_pc_update_done || timeout) begin
          fi_c = 1'b1;
          fe_c = 1'b1;
        end else begin
          hz_c = 1'b1;
          fe_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset masks the Mealy outputs even though RUN would still decode inputs.
  assign hazard     = hz_c & rst_n;
  assign flush_ifid = fi_c & rst_n;
  assign flush_idex = fe_c & rst_n;
  assign hz_state   = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for RUN decode plus
// hand sequences for multi-cycle stalls, ret wait, timeout and reset.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_uses_rs, id_uses_rt, id_is_ret;
  logic [3:0] id_rs, id_rt, ex_reg_rd;
  logic ex_mem_to_reg, ex_reg_write, ex_pc_src, ex_pc_update_done;

  logic hz1, fi1, fe1, err1;
  logic [1:0] st1;
  logic [15:0] sc1;
  logic hz3, fi3, fe3, err3;
  logic [1:0] st3;
  logic [15:0] sc3;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .RET_TIMEOUT(15)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_ret(id_is_ret), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_reg_rd(ex_reg_rd),
    .ex_pc_src(ex_pc_src), .ex_pc_update_done(ex_pc_update_done),
    .hazard(hz1), .flush_ifid(fi1), .flush_idex(fe1),
    .hz_state(st1), .ret_timeout_err(err1), .stall_cycles(sc1)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .RET_TIMEOUT(15)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_ret(id_is_ret), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_reg_rd(ex_reg_rd),
    .ex_pc_src(ex_pc_src), .ex_pc_update_done(ex_pc_update_done),
    .hazard(hz3), .flush_ifid(fi3), .flush_idex(fe3),
    .hz_state(st3), .ret_timeout_err(err3), .stall_cycles(sc3)
  );

  typedef struct {
    logic       v;
    logic [3:0] rs, rt;
    logic       urs, urt, ret, m2r, rw;
    logic [3:0] rd;
    logic       pcs, done;
    logic       hz, fi, fe;
    logic [1:0] st1, st3;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_is_ret = 0;
    ex_mem_to_reg = 0; ex_reg_write = 0; ex_reg_rd = 0;
    ex_pc_src = 0; ex_pc_update_done = 0;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic load_r3();
    id_valid = 1; id_rs = 4'd3; id_uses_rs = 1;
    ex_mem_to_reg = 1; ex_reg_write = 1; ex_reg_rd = 4'd3;
  endtask

  task automatic ret_in_id();
    id_valid = 1; id_is_ret = 1;
  endtask

  initial begin
    idle();
    //         v rs    rt    urs urt ret m2r rw rd   pcs dn  hz fi fe s1 s3
    vecs[0]  = '{1, 4'd3, 4'd0, 1, 0, 0, 1, 1, 4'd3, 0, 0, 1, 0, 1, 0, 1};
    vecs[1]  = '{1, 4'd1, 4'd5, 1, 1, 0, 1, 1, 4'd5, 0, 0, 1, 0, 1, 0, 1};
    vecs[2]  = '{1, 4'd1, 4'd5, 1, 0, 0, 1, 1, 4'd5, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 4'd0, 4'd0, 1, 1, 0, 1, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 4'd3, 4'd0, 1, 0, 0, 1, 0, 4'd3, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 4'd3, 4'd0, 1, 0, 0, 0, 1, 4'd3, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 4'd3, 4'd0, 1, 0, 0, 1, 1, 4'd3, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 4'd3, 4'd0, 1, 0, 0, 1, 1, 4'd3, 1, 0, 0, 1, 1, 0, 0};
    vecs[8]  = '{1, 4'd0, 4'd0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 1, 0, 0, 2, 2};
    vecs[9]  = '{1, 4'd3, 4'd0, 1, 0, 1, 1, 1, 4'd3, 0, 0, 1, 0, 1, 0, 1};
    vecs[10] = '{1, 4'd0, 4'd0, 0, 0, 1, 0, 0, 4'd0, 1, 0, 0, 1, 1, 0, 0};
    vecs[11] = '{0, 4'd0, 4'd0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{1, 4'd2, 4'd4, 1, 1, 0, 1, 1, 4'd7, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{1, 4'd0, 4'd0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 0, 0, 0, 0, 0};

    // reset state, sampled while rst_n is still low
    #2;
    chk("rst_hazard", 16'(hz1), 16'd0);
    chk("rst_flush", 16'({fi1, fe1}), 16'd0);
    chk("rst_state", 16'(st1), 16'd0);
    chk("rst_err", 16'(err1), 16'd0);
    chk("rst_stall", sc1, 16'd0);
    step();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      rst_pulse();
      id_valid = vecs[i].v; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
      id_is_ret = vecs[i].ret; ex_mem_to_reg = vecs[i].m2r;
      ex_reg_write = vecs[i].rw; ex_reg_rd = vecs[i].rd;
      ex_pc_src = vecs[i].pcs; ex_pc_update_done = vecs[i].done;
      #1;
      chk($sformatf("vec%0d_hazard", i), 16'(hz1), 16'(vecs[i].hz));
      chk($sformatf("vec%0d_flush_ifid", i), 16'(fi1), 16'(vecs[i].fi));
      chk($sformatf("vec%0d_flush_idex", i), 16'(fe1), 16'(vecs[i].fe));
      step();
      chk($sformatf("vec%0d_state1", i), 16'(st1), 16'(vecs[i].st1));
      chk($sformatf("vec%0d_state3", i), 16'(st3), 16'(vecs[i].st3));
    end

    // load-use: one bubble vs three, ex_pc_src ignored inside LOAD_STALL
    idle();
    rst_pulse();
    load_r3();
    #1;
    chk("lu_c0_hz3", 16'(hz3), 16'd1);
    chk("lu_c0_st3", 16'(st3), 16'd0);
    step();
    idle();
    ex_pc_src = 1;
    #1;
    chk("lu_c1_st1", 16'(st1), 16'd0);
    chk("lu_c1_fi1", 16'(fi1), 16'd1);
    chk("lu_c1_st3", 16'(st3), 16'd1);
    chk("lu_c1_dut3", 16'({hz3, fi3, fe3}), 16'b101);
    step();
    ex_pc_src = 0;
    #1;
    chk("lu_c2_st3", 16'(st3), 16'd1);
    chk("lu_c2_hz3", 16'(hz3), 16'd1);
    step();
    chk("lu_c3_st3", 16'(st3), 16'd0);
    chk("lu_c3_hz3", 16'(hz3), 16'd0);
    chk("lu_stall1", sc1, 16'd1);
    chk("lu_stall3", sc3, 16'd3);

    // ret resolved four cycles after entering ID
    idle();
    rst_pulse();
    ret_in_id();
    #1;
    chk("ret_c0", 16'({hz1, fi1, fe1}), 16'b100);
    step();
    idle();
    for (int c = 1; c < 4; c++) begin
      #1;
      chk($sformatf("ret_c%0d_out", c), 16'({hz1, fi1, fe1}), 16'b101);
      chk($sformatf("ret_c%0d_st", c), 16'(st1), 16'd2);
      step();
    end
    ex_pc_update_done = 1;
    #1;
    chk("ret_done_out", 16'({hz1, fi1, fe1}), 16'b011);
    step();
    ex_pc_update_done = 0;
    chk("ret_done_st", 16'(st1), 16'd0);
    chk("ret_stall", sc1, 16'd4);
    chk("ret_no_err", 16'(err1), 16'd0);

    // ret never resolved: forced exit on the 15th RET_WAIT cycle
    idle();
    rst_pulse();
    ret_in_id();
    step();
    idle();
    for (int c = 0; c < 14; c++) begin
      #1;
      chk($sformatf("to_w%0d", c), 16'({st1, hz1, fe1}), 16'b1011);
      step();
    end
    #1;
    chk("to_exit_out", 16'({hz1, fi1, fe1}), 16'b011);
    chk("to_err_pre", 16'(err1), 16'd0);
    step();
    chk("to_state", 16'(st1), 16'd0);
    chk("to_err", 16'(err1), 16'd1);
    chk("to_stall", sc1, 16'd15);
    step();
    step();
    chk("to_err_sticky", 16'(err1), 16'd1);

    // async reset in the middle of RET_WAIT, no clock edge involved
    idle();
    ret_in_id();
    step();
    step();
    ex_pc_src = 1;
    #1;
    chk("ar_pre_st", 16'(st1), 16'd2);
    rst_n = 1'b0;
    #1;
    chk("ar_outs", 16'({hz1, fi1, fe1}), 16'd0);
    chk("ar_state", 16'(st1), 16'd0);
    chk("ar_err", 16'(err1), 16'd0);
    chk("ar_stall", sc1, 16'd0);
    step();
    idle();
    load_r3();
    rst_n = 1'b1;
    #1;
    chk("ar_run_out", 16'({hz3, fi3, fe3}), 16'b101);
    step();
    chk("ar_run_st3", 16'(st3), 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
